// File: rtl/bcdn_counter_if.sv
// Control and status bundle for bcdn_counter: count/load strobes in, BCD value and flags out.
// DIGITS must match the counter instance it is bound to.
interface bcdn_counter_if #(
    parameter int unsigned DIGITS = 2
) ();
    logic                  x;
    logic                  dn;
    logic                  ld;
    logic [4*DIGITS-1:0]   ld_val;
    logic                  clr_ovf;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  co;
    logic                  ovf;

    modport master (
        output x, dn, ld, ld_val, clr_ovf,
        input  bcd_out, co, ovf
    );

    modport slave (
        input  x, dn, ld, ld_val, clr_ovf,
        output bcd_out, co, ovf
    );
endinterface

// File: rtl/bcdn_counter.sv
// Parametrised N-digit BCD up/down counter with clamped load, carry/borrow pulse and sticky ovf.
// Define BCD_SAT_EN to saturate at all-9s / all-0s instead of wrapping (co then stays 0).
module bcdn_counter #(
    parameter int unsigned DIGITS = 2
) (
    input logic           clk,
    input logic           reset,
    bcdn_counter_if.slave bus
);
    localparam int unsigned W = 4 * DIGITS;

    // Out-of-range nibbles go to 0 on the way up and to 9 on the way down.
    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] dec_digit(input logic [3:0] d);
        return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
    endfunction

    logic [W-1:0]    cnt_q, cnt_d;
    logic [W-1:0]    up_val, dn_val, ld_clamped;
    logic [DIGITS:0] up_c, dn_c;
    logic            co_q, co_d;
    logic            ovf_q, ovf_d;
    logic            terminal;

    assign up_c[0] = 1'b1;
    assign dn_c[0] = 1'b1;

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        logic [3:0] q;
        logic [3:0] lv;
        assign q  = cnt_q[4*i +: 4];
        assign lv = bus.ld_val[4*i +: 4];

        // A digit steps only when every lower digit is at its rollover value.
        assign up_c[i+1] = up_c[i] & (q == 4'd9);
        assign dn_c[i+1] = dn_c[i] & (q == 4'd0);

        assign up_val[4*i +: 4]     = up_c[i] ? inc_digit(q) : q;
        assign dn_val[4*i +: 4]     = dn_c[i] ? dec_digit(q) : q;
        assign ld_clamped[4*i +: 4] = (lv > 4'd9) ? 4'd9 : lv;
    end

    assign terminal = bus.dn ? dn_c[DIGITS] : up_c[DIGITS];

    always_comb begin
        cnt_d = cnt_q;
        co_d  = 1'b0;
        ovf_d = ovf_q & ~bus.clr_ovf;
        if (bus.ld) begin
            cnt_d = ld_clamped;
        end else if (bus.x) begin
            // Set is applied after the clear so a coincident terminal step wins.
            if (terminal) begin
                ovf_d = 1'b1;
            end
`ifdef BCD_SAT_EN
            if (!terminal) begin
                cnt_d = bus.dn ? dn_val : up_val;
            end
`else
            cnt_d = bus.dn ? dn_val : up_val;
            co_d  = terminal;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            co_q  <= co_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.bcd_out = cnt_q;
    assign bus.co      = co_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bcdn_counter.sv
// Directed self-checking bench for bcdn_counter: a 2-digit and a 4-digit instance share clk/reset.
// Wrap-mode scenarios run in the default build; the saturation scenario runs with BCD_SAT_EN.
module tb_bcdn_counter;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    bcdn_counter_if #(.DIGITS(2)) if2 ();
    bcdn_counter_if #(.DIGITS(4)) if4 ();

    bcdn_counter #(.DIGITS(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    bcdn_counter #(.DIGITS(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle2();
        if2.x = 1'b0; if2.dn = 1'b0; if2.ld = 1'b0; if2.ld_val = '0; if2.clr_ovf = 1'b0;
    endtask

    task automatic idle4();
        if4.x = 1'b0; if4.dn = 1'b0; if4.ld = 1'b0; if4.ld_val = '0; if4.clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle2();
        idle4();
        #1;
        total++;
        if (if2.bcd_out !== 8'h00 || if2.co !== 1'b0 || if2.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_init2: got val=%h co=%b ovf=%b want 00 0 0",
                     if2.bcd_out, if2.co, if2.ovf);
        end
        total++;
        if (if4.bcd_out !== 16'h0000 || if4.co !== 1'b0 || if4.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_init4: got val=%h co=%b ovf=%b want 0000 0 0",
                     if4.bcd_out, if4.co, if4.ovf);
        end
        tick();
        reset = 1'b1;
        // Count up to 47 via load, then one terminal-free step to get a live value.
        if2.ld = 1'b1; if2.ld_val = 8'h46;
        tick();
        if2.ld = 1'b0; if2.x = 1'b1;
        tick();
        if2.x = 1'b0;
        total++;
        if (if2.bcd_out !== 8'h47) begin
            bad++;
            $display("FAIL reset_precount: got %h want 47", if2.bcd_out);
        end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (if2.bcd_out !== 8'h00 || if2.co !== 1'b0 || if2.ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: got val=%h co=%b ovf=%b want 00 0 0",
                     if2.bcd_out, if2.co, if2.ovf);
        end
        #1;
        reset = 1'b1;
        tick();
        total++;
        if (if2.bcd_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_hold: got %h want 00", if2.bcd_out);
        end
    endtask

`ifndef BCD_SAT_EN
    task automatic test_up_count();
        logic [7:0] exp_v;
        int         v;
        if2.x = 1'b1; if2.dn = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            v     = k % 100;
            exp_v = 8'(((v / 10) << 4) | (v % 10));
            total++;
            if (if2.bcd_out !== exp_v || if2.co !== (k == 100) || if2.ovf !== (k == 100)) begin
                bad++;
                $display("FAIL up_count step %0d: got val=%h co=%b ovf=%b want %h %b %b",
                         k, if2.bcd_out, if2.co, if2.ovf, exp_v, (k == 100), (k == 100));
            end
        end
        if2.x = 1'b0;
        tick();
        total++;
        if (if2.bcd_out !== 8'h00 || if2.co !== 1'b0 || if2.ovf !== 1'b1) begin
            bad++;
            $display("FAIL up_hold: got val=%h co=%b ovf=%b want 00 0 1",
                     if2.bcd_out, if2.co, if2.ovf);
        end
        if2.clr_ovf = 1'b1;
        tick();
        if2.clr_ovf = 1'b0;
        total++;
        if (if2.ovf !== 1'b0) begin
            bad++;
            $display("FAIL up_clr_ovf: got %b want 0", if2.ovf);
        end
    endtask

    task automatic test_down();
        if2.ld = 1'b1; if2.ld_val = 8'h10;
        tick();
        if2.ld = 1'b0; if2.x = 1'b1; if2.dn = 1'b1;
        tick();
        total++;
        if (if2.bcd_out !== 8'h09 || if2.co !== 1'b0) begin
            bad++;
            $display("FAIL down_10_09: got val=%h co=%b want 09 0", if2.bcd_out, if2.co);
        end
        tick();
        total++;
        if (if2.bcd_out !== 8'h08) begin
            bad++;
            $display("FAIL down_09_08: got %h want 08", if2.bcd_out);
        end
        if2.x = 1'b0; if2.ld = 1'b1; if2.ld_val = 8'h00;
        tick();
        if2.ld = 1'b0; if2.x = 1'b1;
        tick();
        if2.x = 1'b0;
        total++;
        if (if2.bcd_out !== 8'h99 || if2.co !== 1'b1 || if2.ovf !== 1'b1) begin
            bad++;
            $display("FAIL down_wrap: got val=%h co=%b ovf=%b want 99 1 1",
                     if2.bcd_out, if2.co, if2.ovf);
        end
        if2.clr_ovf = 1'b1;
        tick();
        if2.clr_ovf = 1'b0;
        total++;
        if (if2.bcd_out !== 8'h99 || if2.co !== 1'b0 || if2.ovf !== 1'b0) begin
            bad++;
            $display("FAIL down_clr: got val=%h co=%b ovf=%b want 99 0 0",
                     if2.bcd_out, if2.co, if2.ovf);
        end
    endtask

    task automatic test_load_clamp();
        // From 99, one up step wraps and raises ovf so the load can be seen to keep it.
        if2.x = 1'b1; if2.dn = 1'b0;
        tick();
        total++;
        if (if2.bcd_out !== 8'h00 || if2.co !== 1'b1 || if2.ovf !== 1'b1) begin
            bad++;
            $display("FAIL load_prewrap: got val=%h co=%b ovf=%b want 00 1 1",
                     if2.bcd_out, if2.co, if2.ovf);
        end
        if2.ld = 1'b1; if2.ld_val = 8'hAF;
        tick();
        total++;
        if (if2.bcd_out !== 8'h99 || if2.co !== 1'b0 || if2.ovf !== 1'b1) begin
            bad++;
            $display("FAIL load_clamp_af: got val=%h co=%b ovf=%b want 99 0 1",
                     if2.bcd_out, if2.co, if2.ovf);
        end
        if2.ld_val = 8'h5C; if2.clr_ovf = 1'b1;
        tick();
        if2.ld = 1'b0; if2.clr_ovf = 1'b0; if2.x = 1'b0;
        total++;
        if (if2.bcd_out !== 8'h59 || if2.ovf !== 1'b0) begin
            bad++;
            $display("FAIL load_clr_ovf: got val=%h ovf=%b want 59 0", if2.bcd_out, if2.ovf);
        end
        tick();
        total++;
        if (if2.bcd_out !== 8'h59 || if2.co !== 1'b0) begin
            bad++;
            $display("FAIL load_hold: got val=%h co=%b want 59 0", if2.bcd_out, if2.co);
        end
    endtask

    task automatic test_direction();
        if2.x = 1'b1; if2.dn = 1'b0;
        tick();
        total++;
        if (if2.bcd_out !== 8'h60) begin
            bad++;
            $display("FAIL dir_up: got %h want 60", if2.bcd_out);
        end
        if2.dn = 1'b1;
        tick();
        total++;
        if (if2.bcd_out !== 8'h59) begin
            bad++;
            $display("FAIL dir_down1: got %h want 59", if2.bcd_out);
        end
        tick();
        if2.x = 1'b0;
        total++;
        if (if2.bcd_out !== 8'h58) begin
            bad++;
            $display("FAIL dir_down2: got %h want 58", if2.bcd_out);
        end
    endtask

    task automatic test_wide();
        if4.ld = 1'b1; if4.ld_val = 16'h0999;
        tick();
        if4.ld = 1'b0; if4.x = 1'b1; if4.dn = 1'b0;
        tick();
        if4.x = 1'b0;
        total++;
        if (if4.bcd_out !== 16'h1000 || if4.co !== 1'b0) begin
            bad++;
            $display("FAIL wide_ripple_up: got val=%h co=%b want 1000 0", if4.bcd_out, if4.co);
        end
        if4.x = 1'b1; if4.dn = 1'b1;
        tick();
        if4.x = 1'b0;
        total++;
        if (if4.bcd_out !== 16'h0999) begin
            bad++;
            $display("FAIL wide_ripple_down: got %h want 0999", if4.bcd_out);
        end
        if4.ld = 1'b1; if4.ld_val = 16'h9999;
        tick();
        if4.ld = 1'b0; if4.x = 1'b1; if4.dn = 1'b0;
        tick();
        total++;
        if (if4.bcd_out !== 16'h0000 || if4.co !== 1'b1 || if4.ovf !== 1'b1) begin
            bad++;
            $display("FAIL wide_wrap: got val=%h co=%b ovf=%b want 0000 1 1",
                     if4.bcd_out, if4.co, if4.ovf);
        end
        // Back-to-back terminal steps with a coincident clear: set must win, co stays high.
        if4.dn = 1'b1; if4.clr_ovf = 1'b1;
        tick();
        if4.clr_ovf = 1'b0;
        total++;
        if (if4.bcd_out !== 16'h9999 || if4.co !== 1'b1 || if4.ovf !== 1'b1) begin
            bad++;
            $display("FAIL wide_set_wins: got val=%h co=%b ovf=%b want 9999 1 1",
                     if4.bcd_out, if4.co, if4.ovf);
        end
        if4.dn = 1'b0;
        tick();
        total++;
        if (if4.bcd_out !== 16'h0000 || if4.co !== 1'b1) begin
            bad++;
            $display("FAIL wide_back_to_back: got val=%h co=%b want 0000 1", if4.bcd_out, if4.co);
        end
        if4.x = 1'b0;
        tick();
        total++;
        if (if4.bcd_out !== 16'h0000 || if4.co !== 1'b0 || if4.ovf !== 1'b1) begin
            bad++;
            $display("FAIL wide_idle: got val=%h co=%b ovf=%b want 0000 0 1",
                     if4.bcd_out, if4.co, if4.ovf);
        end
    endtask
`else
    task automatic test_saturate();
        if2.ld = 1'b1; if2.ld_val = 8'h99;
        tick();
        if2.ld = 1'b0; if2.x = 1'b1; if2.dn = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (if2.bcd_out !== 8'h99 || if2.co !== 1'b0 || if2.ovf !== 1'b1) begin
                bad++;
                $display("FAIL sat_up step %0d: got val=%h co=%b ovf=%b want 99 0 1",
                         k, if2.bcd_out, if2.co, if2.ovf);
            end
        end
        if2.x = 1'b0; if2.ld = 1'b1; if2.ld_val = 8'h00; if2.clr_ovf = 1'b1;
        tick();
        if2.ld = 1'b0; if2.clr_ovf = 1'b0; if2.x = 1'b1; if2.dn = 1'b1;
        total++;
        if (if2.ovf !== 1'b0) begin
            bad++;
            $display("FAIL sat_clr: got ovf=%b want 0", if2.ovf);
        end
        tick();
        if2.x = 1'b0;
        total++;
        if (if2.bcd_out !== 8'h00 || if2.co !== 1'b0 || if2.ovf !== 1'b1) begin
            bad++;
            $display("FAIL sat_down: got val=%h co=%b ovf=%b want 00 0 1",
                     if2.bcd_out, if2.co, if2.ovf);
        end
        if2.x = 1'b1; if2.dn = 1'b0;
        tick();
        if2.x = 1'b0;
        total++;
        if (if2.bcd_out !== 8'h01) begin
            bad++;
            $display("FAIL sat_leave: got %h want 01", if2.bcd_out);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
`ifndef BCD_SAT_EN
        test_up_count();
        test_down();
        test_load_clamp();
        test_direction();
        test_wide();
`else
        test_saturate();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcdn_counter.md
Name: bcdn_counter

Overview:
Parametrised N-digit BCD up/down counter; the next generation of the team's fixed two-digit count-up BCD counter.
Adds:
- digit count set by parameter
- direction control and synchronous parallel load with digit clamping
- registered carry/borrow pulse and sticky overflow flag
Used as a decimal event counter and display source; the output feeds the 7-segment decoders directly, least significant digit in the low nibble.

Parameters:
DIGITS, 2, number of BCD digits (1..8); total output width W = 4*DIGITS

Ports:
clk      input   1    system clock, rising edge
reset    input   1    asynchronous, active-low reset
x        input   1    count enable; one step per clock while high
dn       input   1    direction: 0 = count up, 1 = count down; sampled with x
ld       input   1    synchronous load strobe
ld_val   input   W    load value, digit i in bits [4i+3:4i]
clr_ovf  input   1    synchronous clear of ovf
bcd_out  output  W    counter value, digit i in bits [4i+3:4i]
co       output  1    registered one-cycle carry/borrow pulse
ovf      output  1    sticky wrap/limit flag

Behaviour:
Reset:
- reset low, asynchronous: bcd_out = 0, co = 0, ovf = 0.
- Release is clocked normally; the first count occurs on the first rising edge with reset high and x = 1.

Priority each cycle: reset > ld > x. When ld = 1:
- bcd_out <= ld_val with each nibble > 9 clamped to 9 (e.g. ld_val 8'hAF loads 8'h99).
- co <= 0; x and dn are ignored that cycle; ovf is unchanged unless clr_ovf.

Counting, x = 1, ld = 0, up (dn = 0):
- Digit 0 increments.
- Digit i > 0 increments only when all lower digits are 9.
- A digit at 9 that increments becomes 0.
- Terminal: all digits 9. Next value is all 0; co <= 1, ovf <= 1.

Counting, x = 1, ld = 0, down (dn = 1):
- Digit 0 decrements.
- Digit i > 0 decrements only when all lower digits are 0.
- A digit at 0 that decrements becomes 9.
- Terminal: all digits 0. Next value is all 9; co <= 1, ovf <= 1.

co timing:
- co is high for exactly the one cycle following the terminal step; otherwise 0.
- With x held high across consecutive terminal steps, co stays high on each following cycle.

Holding and invalid state:
- x = 0: value holds, co <= 0.
- Invalid internal digits (> 9) cannot occur, because load clamps.
- Digit increment logic must still map any nibble > 9 to 0 when counting up and to 9 when counting down.

ovf:
- Set by any terminal step.
- Cleared by clr_ovf = 1.
- If set and clear coincide, set wins.

Direction change: dn may change on any cycle; it takes effect on that cycle's step with no latency penalty.

Latency: the count, co and ovf update one clock after the sampled inputs; bcd_out is registered with no combinational path from the inputs.

Optional Feature:
BCD_SAT_EN
- Defined: the counter saturates instead of wrapping.
  - Up at all 9s with x = 1: value holds at all 9s, ovf <= 1, co <= 0.
  - Down at all 0s with x = 1: value holds at 0, ovf <= 1, co <= 0.
  - co is never asserted; the port remains, tied 0.
- Undefined: wrap behaviour as described above.

Test Plan:
- DIGITS = 2, reset low mid-count at 8'h47 -> bcd_out = 8'h00, co = 0, ovf = 0 immediately, without a clock edge.
- Up-count 100 cycles from 0 -> bcd_out sequence 00,01,…,09,10,…,99,00; co high only in the cycle after 99->00; ovf = 1 afterwards.
- Load 8'h10, dn = 1, x = 1 for 2 cycles -> 09 then 08; load 8'h00, down 1 step -> 99, co pulse, ovf = 1; clr_ovf -> ovf = 0.
- ld = 1 with ld_val = 8'hAF while x = 1 -> bcd_out = 8'h99, co = 0, no count that cycle; ld together with clr_ovf -> ovf = 0.
- DIGITS = 4: load 16'h0999, up 1 step -> 16'h1000; load 16'h9999, up 1 step -> 16'h0000 with co pulse; simultaneous terminal step and clr_ovf -> ovf = 1.
- BCD_SAT_EN defined, DIGITS = 2: at 99, up 3 cycles -> stays 99, co = 0, ovf = 1; at 00, down 1 cycle -> stays 00.
